// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared parking-lot constants for the conditioner and display.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

  localparam int C_NUM_SLOTS       = 5;
  localparam int C_CLOCK_HZ        = 100000000;
  localparam int C_DEBOUNCE_CYCLES = 1000000;

  // Debounce counter width, never below one bit.
  function automatic int debounce_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage : parking_pkg
`default_nettype wire

// File: rtl/slot_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : slot_debouncer
// Description : Synchronizer, debounce counter and edge pulses for one slot.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_debouncer
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sensor_raw,
  output logic stable,
  output logic stable_next,
  output logic arrive_pulse,
  output logic depart_pulse
);

  localparam int            CW     = debounce_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_arrive;
  logic          r_depart;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_stable_next;

  always_comb begin
    w_stable_next = r_stable;
    w_count_next  = '0;
    if (r_s2 != r_stable) begin
      if (r_count == C_LAST) begin
        w_stable_next = r_s2;
      end else begin
        w_count_next = r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_count  <= '0;
      r_arrive <= 1'b0;
      r_depart <= 1'b0;
    end else begin
      r_s1     <= sensor_raw;
      r_s2     <= r_s1;
      r_stable <= w_stable_next;
      r_count  <= w_count_next;
      // Pulses come from the next-state bit so they line up with the new level.
      r_arrive <= w_stable_next & ~r_stable;
      r_depart <= ~w_stable_next & r_stable;
    end
  end

  assign stable       = r_stable;
  assign stable_next  = w_stable_next;
  assign arrive_pulse = r_arrive;
  assign depart_pulse = r_depart;

endmodule : slot_debouncer
`default_nettype wire

// File: rtl/slot_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : slot_sensor_conditioner
// Description : Debounced slot occupancy with count, full flag and pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module slot_sensor_conditioner
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS       = C_NUM_SLOTS,
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_SLOTS-1:0]           sensor_raw,
  output logic [NUM_SLOTS-1:0]           parking_slots,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupied_count,
  output logic                           full,
  output logic [NUM_SLOTS-1:0]           arrive_pulse,
  output logic [NUM_SLOTS-1:0]           depart_pulse
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0] w_stable_next;
  logic [CNT_W-1:0]     w_count_next;
  logic [CNT_W-1:0]     r_occupied_count;
  logic                 r_full;

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      slot_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_slot_debouncer (
        .clock        (clock),
        .reset_n      (reset_n),
        .sensor_raw   (sensor_raw[i]),
        .stable       (parking_slots[i]),
        .stable_next  (w_stable_next[i]),
        .arrive_pulse (arrive_pulse[i]),
        .depart_pulse (depart_pulse[i])
      );
    end
  endgenerate

  // Count and full track the next-state vector so they change with the slots.
  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_count_next = w_count_next + CNT_W'(w_stable_next[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_occupied_count <= '0;
      r_full           <= 1'b0;
    end else begin
      r_occupied_count <= w_count_next;
      r_full           <= &w_stable_next;
    end
  end

  assign occupied_count = r_occupied_count;
  assign full           = r_full;

endmodule : slot_sensor_conditioner
`default_nettype wire

// File: tb/tb_slot_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_slot_sensor_conditioner
// Description : Directed self-checking bench, DEBOUNCE_CYCLES = 4, 5 slots.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slot_sensor_conditioner;

  localparam int N = 5;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [N-1:0] sensor_raw;
  logic [N-1:0] parking_slots;
  logic [2:0]   occupied_count;
  logic         full;
  logic [N-1:0] arrive_pulse;
  logic [N-1:0] depart_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  slot_sensor_conditioner #(
    .NUM_SLOTS       (N),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sensor_raw     (sensor_raw),
    .parking_slots  (parking_slots),
    .occupied_count (occupied_count),
    .full           (full),
    .arrive_pulse   (arrive_pulse),
    .depart_pulse   (depart_pulse)
  );

  always #5 clock = ~clock;

  // Advance n edges; outputs are then sampled 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] ps, input int cnt,
                            input logic fl, input logic [N-1:0] arr, input logic [N-1:0] dep);
    chk({tag, ".slots"},  32'(parking_slots),  32'(ps));
    chk({tag, ".count"},  32'(occupied_count), 32'(cnt));
    chk({tag, ".full"},   32'(full),           32'(fl));
    chk({tag, ".arrive"}, 32'(arrive_pulse),   32'(arr));
    chk({tag, ".depart"}, 32'(depart_pulse),   32'(dep));
  endtask

  task automatic do_reset(input logic [N-1:0] raw);
    sensor_raw = raw;
    reset_n    = 1'b0;
    tick(3);
    reset_n    = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // All sensors present through reset, accepted 6 edges after release.
    do_reset(5'b11111);
    reset_n = 1'b0;
    tick(1);
    expect_out("rst_hold", 5'b00000, 0, 1'b0, 5'b00000, 5'b00000);
    reset_n = 1'b1;
    tick(5);
    expect_out("rel_e5", 5'b00000, 0, 1'b0, 5'b00000, 5'b00000);
    tick(1);
    expect_out("rel_e6", 5'b11111, 5, 1'b1, 5'b11111, 5'b00000);
    tick(1);
    expect_out("rel_e7", 5'b11111, 5, 1'b1, 5'b00000, 5'b00000);

    // Single arrival on slot 2.
    do_reset(5'b00000);
    tick(3);
    sensor_raw = 5'b00100;
    tick(5);
    expect_out("s2_e5", 5'b00000, 0, 1'b0, 5'b00000, 5'b00000);
    tick(1);
    expect_out("s2_e6", 5'b00100, 1, 1'b0, 5'b00100, 5'b00000);
    tick(1);
    expect_out("s2_e7", 5'b00100, 1, 1'b0, 5'b00000, 5'b00000);

    // Slot 0 bounces: three samples high, one low, never four in a row.
    for (int k = 0; k < 3; k++) begin
      sensor_raw = 5'b00101;
      tick(3);
      chk("bounce_hi.slots", 32'(parking_slots), 32'(5'b00100));
      sensor_raw = 5'b00100;
      tick(1);
      chk("bounce_lo.slots", 32'(parking_slots), 32'(5'b00100));
      chk("bounce_lo.arrive", 32'(arrive_pulse), 32'(5'b00000));
    end
    tick(2);
    chk("bounce_end.slots", 32'(parking_slots), 32'(5'b00100));
    sensor_raw = 5'b00101;
    tick(5);
    expect_out("s0_e5", 5'b00100, 1, 1'b0, 5'b00000, 5'b00000);
    tick(1);
    expect_out("s0_e6", 5'b00101, 2, 1'b0, 5'b00001, 5'b00000);

    // Three simultaneous arrivals fill the lot.
    sensor_raw = 5'b11111;
    tick(6);
    expect_out("fill_e6", 5'b11111, 5, 1'b1, 5'b11010, 5'b00000);
    tick(1);

    // Departure from slot 4 drops full and count together.
    sensor_raw = 5'b01111;
    tick(5);
    expect_out("s4_e5", 5'b11111, 5, 1'b1, 5'b00000, 5'b00000);
    tick(1);
    expect_out("s4_e6", 5'b01111, 4, 1'b0, 5'b00000, 5'b10000);
    tick(1);
    expect_out("s4_e7", 5'b01111, 4, 1'b0, 5'b00000, 5'b00000);

    // Reset at edge 4 discards the pending slot-1 debounce.
    do_reset(5'b00000);
    tick(3);
    sensor_raw = 5'b00010;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    expect_out("s1_rst", 5'b00000, 0, 1'b0, 5'b00000, 5'b00000);
    reset_n = 1'b1;
    tick(5);
    expect_out("s1_e5", 5'b00000, 0, 1'b0, 5'b00000, 5'b00000);
    tick(1);
    expect_out("s1_e6", 5'b00010, 1, 1'b0, 5'b00010, 5'b00000);

    // Slot 0 arrives while slot 3 departs in the same cycle.
    do_reset(5'b01000);
    tick(8);
    chk("swap_pre.slots", 32'(parking_slots), 32'(5'b01000));
    sensor_raw = 5'b00001;
    tick(5);
    expect_out("swap_e5", 5'b01000, 1, 1'b0, 5'b00000, 5'b00000);
    tick(1);
    expect_out("swap_e6", 5'b00001, 1, 1'b0, 5'b00001, 5'b01000);
    tick(1);
    expect_out("swap_e7", 5'b00001, 1, 1'b0, 5'b00000, 5'b00000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_slot_sensor_conditioner
`default_nettype wire
